// File: rtl/counter_load_seq_if.sv
// counter_load_seq_if: stream, counter-side and status signals of the reload
// sequencer. The sequencer connects through the slave modport. The environment
// (stream source plus the counter) connects through the master modport.
//
// Stream handshake: a reload value transfers on every rising clk edge where
// in_valid && in_ready are both high. in_ready does not depend on in_valid.
// While in_valid is high and the transfer has not happened, the source holds
// in_data stable.
interface counter_load_seq_if #(
    parameter int IDATA_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [IDATA_WIDTH-1:0]        in_data;
    logic                          arm;
    logic [OUTPUT_WIDTH-1:0]       count;
    logic                          load;
    logic [IDATA_WIDTH-1:0]        data_in;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          underrun;
    logic [0:0]                    fsm_state;  // debug view of the sequencer FSM

    modport master (
        output in_valid, in_data, arm, count,
        input  in_ready, load, data_in, fifo_level, underrun, fsm_state
    );

    modport slave (
        input  in_valid, in_data, arm, count,
        output in_ready, load, data_in, fifo_level, underrun, fsm_state
    );
endinterface

// File: rtl/counter_load_seq.sv
// counter_load_seq: reload sequencer for a free-running counter.
// Reload values arrive over a valid/ready stream and are buffered in a FIFO.
// Each value is issued on load/data_in at start-up or right after the counter
// wraps from all-ones to zero.
// Optional feature macro COUNTER_LOAD_SEQ_REPEAT_EN: when the FIFO is empty at
// a wrap, the last loaded value is re-issued instead of flagging underrun.
module counter_load_seq #(
    parameter int IDATA_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input logic              clk,
    input logic              reset,
    counter_load_seq_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [IDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [LW-1:0]          level;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   count_max;
    logic [IDATA_WIDTH-1:0] head;

    logic [0:0]             state;
    logic [0:0]             state_nxt;
    logic                   wrap_pending;
    logic                   underrun_q;
    logic                   underrun_nxt;
    logic                   load_c;
    logic [IDATA_WIDTH-1:0] data_c;

`ifdef COUNTER_LOAD_SEQ_REPEAT_EN
    logic [IDATA_WIDTH-1:0] last_val;
    logic                   have_last;
`endif

    assign empty     = (level == '0);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign count_max = (bus.count == {OUTPUT_WIDTH{1'b1}});
    assign head      = mem[rd_ptr];

    // A full FIFO refuses data even when a pop happens in the same cycle.
    assign push = bus.in_valid && !full;
    // Repeat loads come from last_val, so only loads taken from the FIFO pop it.
    assign pop  = load_c && !empty;

    assign bus.in_ready   = !full;
    assign bus.load       = load_c;
    assign bus.data_in    = data_c;
    assign bus.fifo_level = level;
    assign bus.underrun   = underrun_q;
    assign bus.fsm_state  = state;

    // Decide load/data_in and the next FSM state from the wrap flag and FIFO occupancy.
    always_comb begin
        state_nxt    = state;
        load_c       = 1'b0;
        data_c       = empty ? '0 : head;
        underrun_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                // The counter ignores load while at all-ones, so wait one cycle.
                if (bus.arm && !empty && !count_max) begin
                    load_c    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.arm) begin
                    state_nxt = ST_IDLE;
                end else if (wrap_pending) begin
                    if (!empty) begin
                        load_c = 1'b1;
                    end else begin
`ifdef COUNTER_LOAD_SEQ_REPEAT_EN
                        if (have_last) begin
                            load_c = 1'b1;
                            data_c = last_val;
                        end else begin
                            underrun_nxt = 1'b1;
                        end
`else
                        underrun_nxt = 1'b1;
`endif
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, wrap detection and the registered underrun pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wrap_pending <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            wrap_pending <= count_max;
            underrun_q   <= underrun_nxt;
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

`ifdef COUNTER_LOAD_SEQ_REPEAT_EN
    // Remember the most recent value handed to the counter for repeat loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_val  <= '0;
            have_last <= 1'b0;
        end else if (load_c) begin
            last_val  <= data_c;
            have_last <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_counter_load_seq.sv
// tb_counter_load_seq: directed bench for counter_load_seq with a 4-bit counter
// model that loads data_in when load is high and count is not all-ones.
module tb_counter_load_seq;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    counter_load_seq_if #(.IDATA_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(FD)) bus ();

    counter_load_seq #(.IDATA_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Counter model: free-running, takes data_in on load except at all-ones.
    always @(posedge clk) begin
        if (reset)
            bus.count <= '0;
        else if (bus.load && bus.count != 4'hF)
            bus.count <= bus.data_in;
        else
            bus.count <= bus.count + 4'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.count == v) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.arm = 1'b0;
        step();
        step();
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL reset_load got=%0h want=0", bus.load); end
        n_checks++; if (bus.data_in !== 4'h0) begin n_errors++; $display("FAIL reset_data_in got=%0h want=0", bus.data_in); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%0h want=1", bus.in_ready); end
        n_checks++; if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL reset_level got=%0d want=0", bus.fifo_level); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun got=%0h want=0", bus.underrun); end
        reset = 1'b0;
    endtask

    task automatic test_first_load();
        bit ok;
        bus.in_valid = 1'b1; bus.in_data = 4'h5; step();
        bus.in_data = 4'hC; step();
        bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.fifo_level !== 3'd2) begin n_errors++; $display("FAIL first_level_pre got=%0d want=2", bus.fifo_level); end
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL first_noarm_load got=%0h want=0", bus.load); end
        wait_count(4'h3, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL first_wait_count3 got=%0h want=3", bus.count); end
        bus.arm = 1'b1; #1;
        n_checks++; if (bus.load !== 1'b1) begin n_errors++; $display("FAIL first_load got=%0h want=1", bus.load); end
        n_checks++; if (bus.data_in !== 4'h5) begin n_errors++; $display("FAIL first_data_in got=%0h want=5", bus.data_in); end
        step();
        n_checks++; if (bus.count !== 4'h5) begin n_errors++; $display("FAIL first_count got=%0h want=5", bus.count); end
        n_checks++; if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL first_level got=%0d want=1", bus.fifo_level); end
        n_checks++; if (bus.fsm_state !== 1'b1) begin n_errors++; $display("FAIL first_state got=%0h want=1", bus.fsm_state); end
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL first_load_after got=%0h want=0", bus.load); end
    endtask

    task automatic test_wrap_reload();
        bit ok;
        wait_count(4'hF, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL wrap_wait_countF got=%0h want=f", bus.count); end
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL wrap_load_at_f got=%0h want=0", bus.load); end
        step();
        n_checks++; if (bus.count !== 4'h0) begin n_errors++; $display("FAIL wrap_count0 got=%0h want=0", bus.count); end
        n_checks++; if (bus.load !== 1'b1) begin n_errors++; $display("FAIL wrap_load got=%0h want=1", bus.load); end
        n_checks++; if (bus.data_in !== 4'hC) begin n_errors++; $display("FAIL wrap_data_in got=%0h want=c", bus.data_in); end
        step();
        n_checks++; if (bus.count !== 4'hC) begin n_errors++; $display("FAIL wrap_countC got=%0h want=c", bus.count); end
        n_checks++; if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL wrap_level got=%0d want=0", bus.fifo_level); end
    endtask

    task automatic test_empty_wrap();
        bit ok;
        wait_count(4'hF, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL empty_wait_countF got=%0h want=f", bus.count); end
        step();
`ifdef COUNTER_LOAD_SEQ_REPEAT_EN
        n_checks++; if (bus.load !== 1'b1) begin n_errors++; $display("FAIL repeat_load got=%0h want=1", bus.load); end
        n_checks++; if (bus.data_in !== 4'hC) begin n_errors++; $display("FAIL repeat_data_in got=%0h want=c", bus.data_in); end
        step();
        n_checks++; if (bus.count !== 4'hC) begin n_errors++; $display("FAIL repeat_count got=%0h want=c", bus.count); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL repeat_underrun got=%0h want=0", bus.underrun); end
`else
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL underrun_load got=%0h want=0", bus.load); end
        n_checks++; if (bus.data_in !== 4'h0) begin n_errors++; $display("FAIL underrun_data_in got=%0h want=0", bus.data_in); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_early got=%0h want=0", bus.underrun); end
        step();
        n_checks++; if (bus.count !== 4'h1) begin n_errors++; $display("FAIL underrun_count1 got=%0h want=1", bus.count); end
        n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL underrun_pulse got=%0h want=1", bus.underrun); end
        step();
        n_checks++; if (bus.count !== 4'h2) begin n_errors++; $display("FAIL underrun_count2 got=%0h want=2", bus.count); end
        n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_end got=%0h want=0", bus.underrun); end
`endif
    endtask

    task automatic test_full_and_pushpop();
        bit ok;
        bus.arm = 1'b0; #1;
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL disarm_load got=%0h want=0", bus.load); end
        step();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 4'(i + 1);
            #1;
            n_checks++;
            if (bus.in_ready !== (i < 4)) begin
                n_errors++; $display("FAIL full_in_ready_%0d got=%0h want=%0h", i, bus.in_ready, (i < 4));
            end
            step();
        end
        bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.fifo_level !== 3'd4) begin n_errors++; $display("FAIL full_level got=%0d want=4", bus.fifo_level); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready got=%0h want=0", bus.in_ready); end
        n_checks++; if (bus.data_in !== 4'h1) begin n_errors++; $display("FAIL full_head got=%0h want=1", bus.data_in); end
        if (bus.count == 4'hF) step();
        bus.arm = 1'b1; #1;
        n_checks++; if (bus.load !== 1'b1) begin n_errors++; $display("FAIL rearm_load got=%0h want=1", bus.load); end
        step();
        n_checks++; if (bus.fifo_level !== 3'd3) begin n_errors++; $display("FAIL rearm_level got=%0d want=3", bus.fifo_level); end
        n_checks++; if (bus.count !== 4'h1) begin n_errors++; $display("FAIL rearm_count got=%0h want=1", bus.count); end
        wait_count(4'h0, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL pp_wait_wrap1 got=%0h want=0", bus.count); end
        n_checks++; if (bus.data_in !== 4'h2 || bus.load !== 1'b1) begin n_errors++; $display("FAIL pp_load2 got=%0h/%0h want=2/1", bus.data_in, bus.load); end
        step();
        n_checks++; if (bus.fifo_level !== 3'd2) begin n_errors++; $display("FAIL pp_level2 got=%0d want=2", bus.fifo_level); end
        wait_count(4'h0, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL pp_wait_wrap2 got=%0h want=0", bus.count); end
        bus.in_valid = 1'b1; bus.in_data = 4'h6; #1;
        n_checks++; if (bus.load !== 1'b1 || bus.data_in !== 4'h3) begin n_errors++; $display("FAIL pp_load3 got=%0h/%0h want=1/3", bus.load, bus.data_in); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL pp_in_ready got=%0h want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.fifo_level !== 3'd2) begin n_errors++; $display("FAIL pp_level_same got=%0d want=2", bus.fifo_level); end
        n_checks++; if (bus.count !== 4'h3) begin n_errors++; $display("FAIL pp_count got=%0h want=3", bus.count); end
    endtask

    task automatic test_arm_at_wrap_and_reset();
        bit ok;
        bus.arm = 1'b0;
        step();
        n_checks++; if (bus.fsm_state !== 1'b0) begin n_errors++; $display("FAIL idle_state got=%0h want=0", bus.fsm_state); end
        wait_count(4'hF, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL armwrap_wait got=%0h want=f", bus.count); end
        bus.arm = 1'b1; #1;
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL armwrap_load_at_f got=%0h want=0", bus.load); end
        step();
        n_checks++; if (bus.count !== 4'h0) begin n_errors++; $display("FAIL armwrap_count0 got=%0h want=0", bus.count); end
        n_checks++; if (bus.load !== 1'b1 || bus.data_in !== 4'h4) begin n_errors++; $display("FAIL armwrap_load got=%0h/%0h want=1/4", bus.load, bus.data_in); end
        step();
        n_checks++; if (bus.count !== 4'h4) begin n_errors++; $display("FAIL armwrap_count4 got=%0h want=4", bus.count); end
        n_checks++; if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL armwrap_level got=%0d want=1", bus.fifo_level); end
        bus.in_valid = 1'b1; bus.in_data = 4'h7; step();
        bus.in_data = 4'h8; step();
        bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.fifo_level !== 3'd3) begin n_errors++; $display("FAIL midrun_level got=%0d want=3", bus.fifo_level); end
        n_checks++; if (bus.fsm_state !== 1'b1) begin n_errors++; $display("FAIL midrun_state got=%0h want=1", bus.fsm_state); end
        reset = 1'b1;
        step();
        n_checks++; if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL midreset_level got=%0d want=0", bus.fifo_level); end
        n_checks++; if (bus.fsm_state !== 1'b0) begin n_errors++; $display("FAIL midreset_state got=%0h want=0", bus.fsm_state); end
        n_checks++; if (bus.load !== 1'b0) begin n_errors++; $display("FAIL midreset_load got=%0h want=0", bus.load); end
        n_checks++; if (bus.data_in !== 4'h0) begin n_errors++; $display("FAIL midreset_data_in got=%0h want=0", bus.data_in); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_in_ready got=%0h want=1", bus.in_ready); end
        reset = 1'b0;
        step();
        n_checks++; if (bus.load !== 1'b0 || bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL postreset got=%0h/%0d want=0/0", bus.load, bus.fifo_level); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_wrap_reload();
        test_empty_wrap();
        test_full_and_pushpop();
        test_arm_at_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
